// File: rtl/column_move_collector.sv
`default_nettype none
// ============================================================================
// Module      : column_move_collector
// Description : Column-level move collector. Waits for each of NUM_SQ
//               per-square move generators to report done, then drains that
//               square's show-ahead move FIFO into one local show-ahead FIFO
//               that the board-level move arbiter reads.
// Ports       : clk, reset     - clock, synchronous active-high reset
//               start          - pulse: clear served flags, begin new position
//               sq_done[i]     - square i finished generating (level)
//               sq_empty[i]    - square i FIFO empty
//               sq_data        - square i FIFO head at [i*MOVE_W +: MOVE_W]
//               sq_rden        - pop strobe to square FIFOs (one-hot or zero)
//               out_rden       - pop local FIFO head
//               out_data       - local FIFO head (valid while !out_empty)
//               out_empty      - local FIFO empty
//               out_count      - local FIFO occupancy
//               done           - every square drained for this position
// Options     : COLUMN_COLLECT_RR_EN - round-robin square selection instead
//               of fixed lowest-index priority.
// Revision    : 1.0 - initial release
// ============================================================================
module column_move_collector #(
    parameter int NUM_SQ = 8,
    parameter int MOVE_W = 48,
    parameter int DEPTH  = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NUM_SQ-1:0]           sq_done,
    input  logic [NUM_SQ-1:0]           sq_empty,
    input  logic [NUM_SQ*MOVE_W-1:0]    sq_data,
    output logic [NUM_SQ-1:0]           sq_rden,
    input  logic                        out_rden,
    output logic [MOVE_W-1:0]           out_data,
    output logic                        out_empty,
    output logic [$clog2(DEPTH+1)-1:0]  out_count,
    output logic                        done
);

    localparam int PTR_W = (NUM_SQ > 1) ? $clog2(NUM_SQ) : 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [NUM_SQ-1:0]   served_q, served_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;

    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [MOVE_W-1:0]   mem_q [DEPTH];

    logic [MOVE_W-1:0]   sq_word [NUM_SQ];
    logic [NUM_SQ-1:0]   eligible;
    logic                pick_valid;
    logic [PTR_W-1:0]    pick_idx;
    logic                full;
    logic                push;
    logic                pop;

`ifdef COLUMN_COLLECT_RR_EN
    localparam logic [PTR_W-1:0] LAST_INIT = PTR_W'(NUM_SQ - 1);
    logic [PTR_W-1:0]    last_q, last_d;
    logic [PTR_W-1:0]    cand;
`endif

    // Unpack the flat source bus into one word per square.
    generate
        for (genvar gi = 0; gi < NUM_SQ; gi++) begin : g_slice
            assign sq_word[gi] = sq_data[gi*MOVE_W +: MOVE_W];
        end
    endgenerate

    assign eligible = sq_done & ~served_q;

    // ------------------------------------------------------------------
    // Source selection
    // ------------------------------------------------------------------
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
`ifdef COLUMN_COLLECT_RR_EN
        cand       = '0;
        // Scan starting just after the last square picked, wrapping.
        for (int k = 0; k < NUM_SQ; k++) begin
            cand = PTR_W'((int'(last_q) + 1 + k) % NUM_SQ);
            if (!pick_valid && eligible[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
`else
        for (int k = 0; k < NUM_SQ; k++) begin
            if (!pick_valid && eligible[PTR_W'(k)]) begin
                pick_valid = 1'b1;
                pick_idx   = PTR_W'(k);
            end
        end
`endif
    end

    // ------------------------------------------------------------------
    // Control FSM: next state and square read strobe
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        served_d = served_q;
        ptr_d    = ptr_q;
        sq_rden  = '0;
`ifdef COLUMN_COLLECT_RR_EN
        last_d   = last_q;
`endif

        case (state_q)
            ST_WAIT: begin
                if (&served_q) begin
                    state_d = ST_DONE;
                end else if (pick_valid) begin
                    ptr_d   = pick_idx;
                    state_d = ST_DRAIN;
`ifdef COLUMN_COLLECT_RR_EN
                    last_d  = pick_idx;
`endif
                end
            end
            ST_DRAIN: begin
                // Empty ends the drain regardless of sq_done; a full local
                // FIFO simply withholds the pop and the state holds.
                if (sq_empty[ptr_q]) begin
                    served_d[ptr_q] = 1'b1;
                    state_d         = ST_WAIT;
                end else if (!full) begin
                    sq_rden[ptr_q]  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase

        // Re-arm for a new position; local FIFO contents are untouched.
        if (start) begin
            served_d = '0;
            state_d  = ST_WAIT;
`ifdef COLUMN_COLLECT_RR_EN
            last_d   = LAST_INIT;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Local FIFO bookkeeping
    // ------------------------------------------------------------------
    assign full      = (count_q == FULL_COUNT);
    assign out_empty = (count_q == '0);
    // sq_rden is already gated on full, so a same-cycle pop never lets a
    // push into a full FIFO.
    assign push      = |sq_rden;
    assign pop       = out_rden & ~out_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    assign out_data  = mem_q[rd_ptr_q];
    assign out_count = count_q;
    assign done      = (state_q == ST_DONE);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_WAIT;
            served_q <= '0;
            ptr_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
`ifdef COLUMN_COLLECT_RR_EN
            last_q   <= LAST_INIT;
`endif
        end else begin
            state_q  <= state_d;
            served_q <= served_d;
            ptr_q    <= ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
`ifdef COLUMN_COLLECT_RR_EN
            last_q   <= last_d;
`endif
        end
    end

    // Storage array carries no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sq_word[ptr_q];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_column_move_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_column_move_collector
// Description : Self-checking bench for column_move_collector. Square FIFOs
//               are modelled as arrays in the bench; every move loaded is
//               queued in expected drain order, and a negedge monitor pops
//               the local FIFO at a random rate and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_column_move_collector;

    localparam int NUM_SQ = 8;
    localparam int MOVE_W = 48;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int SLOTS  = 64;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       start;
    logic [NUM_SQ-1:0]          sq_done;
    logic [NUM_SQ-1:0]          sq_empty;
    logic [NUM_SQ*MOVE_W-1:0]   sq_data;
    logic [NUM_SQ-1:0]          sq_rden;
    logic                       out_rden = 1'b0;
    logic [MOVE_W-1:0]          out_data;
    logic                       out_empty;
    logic [CW-1:0]              out_count;
    logic                       done;

    column_move_collector #(
        .NUM_SQ (NUM_SQ),
        .MOVE_W (MOVE_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sq_done   (sq_done),
        .sq_empty  (sq_empty),
        .sq_data   (sq_data),
        .sq_rden   (sq_rden),
        .out_rden  (out_rden),
        .out_data  (out_data),
        .out_empty (out_empty),
        .out_count (out_count),
        .done      (done)
    );

    always #5 clk = ~clk;

    int                tests = 0;
    int                fails = 0;
    logic [MOVE_W-1:0] sb [$];
    logic [MOVE_W-1:0] store [NUM_SQ][SLOTS];
    int                head [NUM_SQ];
    int                tail [NUM_SQ];
    int                model_count = 0;
    logic [NUM_SQ-1:0] rden_s = '0;
    int                pop_pct = 100;
    bit                flush_req = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Square FIFO models: pop on the strobe seen before the edge, then
    // present the new heads a little after the edge.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            model_count = 0;
        end else begin
            model_count = model_count + $countones(rden_s)
                          - ((out_rden && model_count > 0) ? 1 : 0);
        end
        for (int i = 0; i < NUM_SQ; i++) begin
            if (rden_s[i] && head[i] != tail[i]) head[i] = head[i] + 1;
        end
        if (flush_req) begin
            for (int i = 0; i < NUM_SQ; i++) head[i] = tail[i];
            flush_req = 1'b0;
        end
        for (int i = 0; i < NUM_SQ; i++) begin
            sq_empty[i] = (head[i] == tail[i]);
            sq_data[i*MOVE_W +: MOVE_W] = store[i][head[i] % SLOTS];
        end
    end

    // Output monitor and scoreboard checker.
    always @(negedge clk) begin
        logic [MOVE_W-1:0] exp;
        rden_s = sq_rden;
        if (reset) begin
            out_rden = 1'b0;
        end else begin
            check("out_count", 64'(out_count), 64'(model_count));
            check("out_empty", 64'(out_empty), 64'(model_count == 0));
            if ($countones(sq_rden) > 1) check("rden_onehot", 64'(sq_rden), 64'(0));
            if (model_count == DEPTH && sq_rden != 0) check("rden_when_full", 64'(sq_rden), 64'(0));
            if ((sq_rden & ~sq_done) != 0) check("rden_before_done", 64'(sq_rden & ~sq_done), 64'(0));
            if ((sq_rden & sq_empty) != 0) check("rden_on_empty_src", 64'(sq_rden & sq_empty), 64'(0));
            if (!out_empty && $urandom_range(99) < pop_pct) begin
                out_rden = 1'b1;
                if (sb.size() == 0) begin
                    check("out_unexpected_entry", 64'(out_data), 64'(0) - 64'(1));
                end else begin
                    exp = sb.pop_front();
                    check("out_data", 64'(out_data), 64'(exp));
                end
            end else begin
                out_rden = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int sq, input int n);
        logic [MOVE_W-1:0] v;
        for (int j = 0; j < n; j++) begin
            v = {8'(sq), 8'(j), 32'($urandom)};
            store[sq][tail[sq] % SLOTS] = v;
            tail[sq] = tail[sq] + 1;
            sb.push_back(v);
        end
    endtask

    task automatic wait_done(input int bound, input string nm);
        int n;
        n = 0;
        while (!done && n < bound) begin
            tick();
            n++;
        end
        check(nm, 64'(done), 64'(1));
    endtask

    task automatic drain_out(input string nm);
        int n;
        n = 0;
        pop_pct = 100;
        while ((sb.size() != 0 || !out_empty) && n < 200) begin
            tick();
            n++;
        end
        check(nm, 64'(sb.size()), 64'(0));
    endtask

    task automatic release_in_order(input int order [NUM_SQ], input string nm);
        int n;
        for (int k = 0; k < NUM_SQ; k++) begin
            sq_done[order[k]] = 1'b1;
            n = 0;
            while (head[order[k]] != tail[order[k]] && n < 200) begin
                tick();
                n++;
            end
            repeat (3) tick();
            if (k < NUM_SQ - 1) check({nm, "_early_done"}, 64'(done), 64'(0));
        end
    endtask

    initial begin
        int n;
        int h0;
        int cnt;
        int order [NUM_SQ];
        int tmp;
        int r;
        reset    = 1'b1;
        start    = 1'b0;
        sq_done  = '0;
        sq_empty = '1;
        sq_data  = '0;
        repeat (2) tick();
        check("reset_count", 64'(out_count), 64'(0));
        check("reset_empty", 64'(out_empty), 64'(1));
        check("reset_done", 64'(done), 64'(0));
        check("reset_rden", 64'(sq_rden), 64'(0));
        reset = 1'b0;
        tick();

        // Single populated square, no reads: two pushes and bounded latency.
        pop_pct = 0;
        load(3, 2);
        repeat (2) tick();
        sq_done = '1;
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check("t1_done", 64'(done), 64'(1));
        check("t1_latency_le_19", 64'(n <= 19), 64'(1));
        check("t1_count", 64'(out_count), 64'(2));
        drain_out("t1_drain");

        // Restart from DONE with one refilled square.
        load(1, 1);
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_rearm_done_low", 64'(done), 64'(0));
        wait_done(100, "t4_done");
        drain_out("t4_drain");

        // Back-pressure: 6 moves into a 4-deep FIFO with no reads.
        pop_pct = 0;
        load(0, 6);
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        check("t2_stall_count", 64'(out_count), 64'(DEPTH));
        check("t2_stall_rden", 64'(sq_rden), 64'(0));
        check("t2_stall_done", 64'(done), 64'(0));
        pop_pct = 100;
        wait_done(100, "t2_done");
        drain_out("t2_drain");

        // Squares released one at a time in a scrambled order.
        order = '{7, 2, 5, 0, 3, 6, 1, 4};
        for (int k = 0; k < NUM_SQ; k++) load(order[k], int'($urandom_range(4)));
        repeat (2) tick();
        pop_pct = 60;
        sq_done = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        release_in_order(order, "t3");
        wait_done(100, "t3_done");
        drain_out("t3_drain");

        // Reset in the middle of draining square 4.
        pop_pct = 0;
        load(4, 5);
        repeat (2) tick();
        h0 = head[4];
        sq_done = '1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (head[4] != h0 + 3 && n < 100) begin
            tick();
            n++;
        end
        check("t5_three_popped", 64'(head[4] - h0), 64'(3));
        reset = 1'b1;
        sq_done = '0;
        sb.delete();
        flush_req = 1'b1;
        tick();
        check("t5_rden", 64'(sq_rden), 64'(0));
        check("t5_empty", 64'(out_empty), 64'(1));
        check("t5_done", 64'(done), 64'(0));
        check("t5_count", 64'(out_count), 64'(0));
        reset = 1'b0;
        repeat (3) tick();
        check("t5_wait_not_done", 64'(done), 64'(0));

        // Randomised positions.
        for (int p = 0; p < 12; p++) begin
            pop_pct = 20 + int'($urandom_range(80));
            for (int k = 0; k < NUM_SQ; k++) order[k] = k;
            r = int'($urandom_range(1));
            if (r == 1) begin
                for (int k = NUM_SQ - 1; k > 0; k--) begin
                    cnt = int'($urandom_range(k));
                    tmp = order[k];
                    order[k] = order[cnt];
                    order[cnt] = tmp;
                end
            end
            for (int k = 0; k < NUM_SQ; k++) load(order[k], int'($urandom_range(5)));
            repeat (2) tick();
            sq_done = (r == 1) ? '0 : '1;
            start = 1'b1;
            tick();
            start = 1'b0;
            if (r == 1) release_in_order(order, "rnd_seq");
            wait_done(400, "rnd_done");
            drain_out("rnd_drain");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
